// File: rtl/dec_pkg.sv
// Shared definitions for the dec_* decoder family.
//   dec_state_e : decoder operating state (IDLE, DIRECT, SCAN)
//   onehot()    : index -> one-hot vector at maximum supported width;
//                 callers truncate to their own OUT_W.
package dec_pkg;

  // Largest select width any decoder of this family may be built with.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } dec_state_e;

  // 1 << idx at the widest supported output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Dwell counter: counts 0..HOLD_CYCLES-1 while en is high and raises
// step_c (combinational) during the last count; wraps to 0 on step.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (takes priority over counting)
//   en         : count enable
//   step_c     : high in the cycle the count sits at HOLD_CYCLES-1 with en
module dec_dwell_cnt #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic step_c
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign step_c = en && (cnt_q == LAST);

  // Count register; clear wins over count, step wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || step_c) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dec_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable.
//   Direct mode (mode=0): selection loaded via sel_valid/sel_ready.
//   Scan mode   (mode=1): one-hot walks through every line, each held
//                         HOLD_CYCLES clocks; wrap pulses on rollover.
// Optional build macro DEC_SCAN_DIR_EN adds input dir (1 = scan downward).
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   enable          : 0 forces out inactive
//   mode            : 0 direct, 1 scan
//   dir             : scan direction (only with DEC_SCAN_DIR_EN)
//   sel_valid, sel  : direct-mode selection request
//   sel_ready       : combinational, enable & ~mode & rst_n
//   out, index      : registered one-hot strobe and its line index
//   wrap            : registered one-cycle scan rollover pulse
module dec_scan
  import dec_pkg::*;
#(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned HOLD_CYCLES = 1,
  localparam int unsigned OUT_W      = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
`ifdef DEC_SCAN_DIR_EN
  input  logic             dir,
`endif
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] index,
  output logic             wrap
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("dec_scan: HOLD_CYCLES must be >= 1");
  end
  if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
    $error("dec_scan: SEL_W out of supported range");
  end

  // Decode at this instance's width.
  function automatic logic [OUT_W-1:0] line(input logic [SEL_W-1:0] idx);
    return OUT_W'(onehot(MAX_SEL_W'(idx)));
  endfunction

  dec_state_e       state_q, state_d;
  logic [SEL_W-1:0] index_q, index_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  // A selection accepted on the cycle DIRECT is entered is applied one
  // edge later, since the entry edge re-asserts the retained index.
  logic             pend_vld_q, pend_vld_d;
  logic [SEL_W-1:0] pend_sel_q, pend_sel_d;

  logic             xfer;
  logic             scan_dn;
  logic             dwell_en;
  logic             step_c;
  logic [SEL_W-1:0] step_idx;
  logic             step_wrap;

`ifdef DEC_SCAN_DIR_EN
  assign scan_dn = dir;
`else
  assign scan_dn = 1'b0;
`endif

  assign sel_ready = enable & ~mode & rst_n;
  assign xfer      = sel_valid & sel_ready;

  // Dwell runs only while staying in scan; any other edge restarts it.
  assign dwell_en  = (state_q == ST_SCAN) & enable & mode;

  dec_dwell_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (~dwell_en),
    .en     (dwell_en),
    .step_c (step_c)
  );

  // Next scan position and rollover flag for the active direction.
  always_comb begin
    step_idx  = index_q + SEL_W'(1);
    step_wrap = (index_q == '1);
    if (scan_dn) begin
      step_idx  = index_q - SEL_W'(1);
      step_wrap = (index_q == '0);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    out_d      = out_q;
    wrap_d     = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;

    if (!enable) begin
      state_d    = ST_IDLE;
      out_d      = '0;
      pend_vld_d = 1'b0;
    end else if (!mode) begin
      state_d = ST_DIRECT;
      if (state_q != ST_DIRECT) begin
        out_d      = line(index_q);
        pend_vld_d = xfer;
        pend_sel_d = sel;
      end else if (xfer) begin
        index_d    = sel;
        out_d      = line(sel);
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        index_d    = pend_sel_q;
        out_d      = line(pend_sel_q);
        pend_vld_d = 1'b0;
      end else begin
        out_d = line(index_q);
      end
    end else begin
      state_d    = ST_SCAN;
      pend_vld_d = 1'b0;
      if (state_q != ST_SCAN) begin
        out_d = line(index_q);
      end else if (step_c) begin
        index_d = step_idx;
        out_d   = line(step_idx);
        wrap_d  = step_wrap;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      out_q      <= '0;
      wrap_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      out_q      <= out_d;
      wrap_q     <= wrap_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  assign out   = out_q;
  assign index = index_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Bench for dec_scan: two instances (HOLD_CYCLES=1 and 2) share stimulus
// and are compared every cycle against a behavioural model.
module tb_dec_scan;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;
`ifdef DEC_SCAN_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, md, sv, dr;
  logic [SEL_W-1:0] s;

  logic             rdy [2];
  logic [OUT_W-1:0] out [2];
  logic [SEL_W-1:0] idx [2];
  logic             wrp [2];

  always #5 clk = ~clk;

  dec_scan #(.SEL_W(SEL_W), .HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en), .mode(md),
`ifdef DEC_SCAN_DIR_EN
    .dir(dr),
`endif
    .sel_valid(sv), .sel(s), .sel_ready(rdy[0]),
    .out(out[0]), .index(idx[0]), .wrap(wrp[0])
  );

  dec_scan #(.SEL_W(SEL_W), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en), .mode(md),
`ifdef DEC_SCAN_DIR_EN
    .dir(dr),
`endif
    .sel_valid(sv), .sel(s), .sel_ready(rdy[1]),
    .out(out[1]), .index(idx[1]), .wrap(wrp[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 off, 1 direct, 2 scan.
  int m_phase [2];
  int m_idx   [2];
  bit m_on    [2];
  bit m_wrap  [2];
  int m_dwell [2];
  bit m_pend  [2];
  int m_psel  [2];

  function automatic int hold_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_idx[k] = 0; m_on[k] = 0; m_wrap[k] = 0;
      m_dwell[k] = 0; m_pend[k] = 0; m_psel[k] = 0;
    end
  endtask

  // One rising edge, using the inputs currently applied.
  task automatic mdl_edge();
    bit ready, dn;
    ready = en && !md;
    dn    = DIR_EN && dr;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 0;
      if (!en) begin
        m_phase[k] = 0; m_on[k] = 0; m_dwell[k] = 0; m_pend[k] = 0;
      end else if (!md) begin
        m_dwell[k] = 0;
        m_on[k]    = 1;
        if (m_phase[k] != 1) begin
          m_pend[k] = sv && ready;
          m_psel[k] = int'(s);
        end else if (sv && ready) begin
          m_idx[k] = int'(s); m_pend[k] = 0;
        end else if (m_pend[k]) begin
          m_idx[k] = m_psel[k]; m_pend[k] = 0;
        end
        m_phase[k] = 1;
      end else begin
        m_pend[k] = 0;
        m_on[k]   = 1;
        if (m_phase[k] != 2) begin
          m_dwell[k] = 0;
        end else if (m_dwell[k] == hold_of(k) - 1) begin
          m_dwell[k] = 0;
          if (dn) begin
            m_idx[k]  = (m_idx[k] + OUT_W - 1) % OUT_W;
            m_wrap[k] = (m_idx[k] == OUT_W - 1);
          end else begin
            m_idx[k]  = (m_idx[k] + 1) % OUT_W;
            m_wrap[k] = (m_idx[k] == 0);
          end
        end else begin
          m_dwell[k]++;
        end
        m_phase[k] = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_out%0d", tag, k), 32'(out[k]), m_on[k] ? (32'd1 << m_idx[k]) : 32'd0);
      check($sformatf("%s_idx%0d", tag, k), 32'(idx[k]), 32'(m_idx[k]));
      check($sformatf("%s_wrap%0d", tag, k), 32'(wrp[k]), 32'(m_wrap[k]));
    end
  endtask

  task automatic drive(input logic e, input logic m, input logic v, input int sl, input logic d);
    en = e; md = m; sv = v; s = SEL_W'(sl); dr = d;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(e && !m && rst_n));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) mdl_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  logic [7:0] scan_exp [6];
  logic       scan_wrp [6];

  initial begin
    mdl_reset();
    rst_n = 1'b0;
    en = 1'b1; md = 1'b0; sv = 1'b0; s = '0; dr = 1'b0;
    #1;
    check("rst_out", 32'(out[1]), 32'h0);
    check("rst_idx", 32'(idx[1]), 32'h0);
    check("rst_rdy", 32'(rdy[1]), 32'h0);
    tick("rst");
    tick("rst");

    // First enable after reset asserts line 0.
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0);
    tick("en0");
    check("en0_line0", 32'(out[1]), 32'h01);

    // Back-to-back direct loads.
    drive(1, 0, 1, 5, 0); tick("ld5");
    check("ld5_out", 32'(out[1]), 32'h20);
    drive(1, 0, 1, 2, 0); tick("ld2");
    check("ld2_out", 32'(out[1]), 32'h04);
    drive(1, 0, 0, 0, 0); tick("hold");

    // Disabled: request not accepted, output inactive.
    drive(0, 0, 1, 3, 0);
    check("dis_rdy", 32'(rdy[1]), 32'h0);
    tick("dis");
    check("dis_out", 32'(out[1]), 32'h0);
    tick("dis");

    // Scan from index 6 with two-cycle dwell.
    drive(1, 0, 0, 0, 0); tick("re_en");
    drive(1, 0, 1, 6, 0); tick("ld6");
    scan_exp = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01};
    scan_wrp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      tick("scan");
      check($sformatf("scan_out_%0d", i), 32'(out[1]), 32'(scan_exp[i]));
      check($sformatf("scan_wrap_%0d", i), 32'(wrp[1]), 32'(scan_wrp[i]));
    end

    // Mode switch mid-dwell at index 3 with a same-cycle request.
    drive(1, 0, 1, 3, 0); tick("msw_a");
    tick("msw_b");
    drive(1, 1, 0, 0, 0); tick("msw_scan");
    drive(1, 0, 1, 7, 0); tick("msw_dir");
    check("msw_out0", 32'(out[1]), 32'h08);
    check("msw_idx0", 32'(idx[1]), 32'h3);
    drive(1, 0, 0, 0, 0); tick("msw_ld");
    check("msw_out1", 32'(out[1]), 32'h80);
    check("msw_wrap", 32'(wrp[1]), 32'h0);

    // Asynchronous reset mid-scan at index 4.
    drive(1, 0, 1, 4, 0); tick("ar_ld");
    drive(1, 1, 0, 0, 0); tick("ar_scan");
    check("ar_idx_pre", 32'(idx[1]), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    check("ar_out", 32'(out[1]), 32'h0);
    check("ar_idx", 32'(idx[1]), 32'h0);
    check_all("ar");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEC_SCAN_DIR_EN
    // Downward scan on the single-cycle-dwell instance from index 1.
    drive(1, 0, 1, 1, 1); tick("dn_entry");
    tick("dn_ld");
    drive(1, 1, 0, 0, 1);
    tick("dn0"); check("dn0_out", 32'(out[0]), 32'h02);
    tick("dn1"); check("dn1_out", 32'(out[0]), 32'h01);
    tick("dn2"); check("dn2_out", 32'(out[0]), 32'h80);
    check("dn2_wrap", 32'(wrp[0]), 32'h1);
    tick("dn3"); check("dn3_out", 32'(out[0]), 32'h40);
    check("dn3_wrap", 32'(wrp[0]), 32'h0);
`endif

    // Randomized operation.
    for (int i = 0; i < 800; i++) begin
      logic e, m, v, d;
      e = ($urandom_range(0, 9) != 0);
      m = ($urandom_range(0, 7) == 0) ? ~md : md;
      v = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 15) == 0) ? ~dr : dr;
      drive(e, m, v, int'($urandom_range(0, OUT_W - 1)), d);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        mdl_reset();
        check_all("rnd_ar");
        #1 rst_n = 1'b1;
      end
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
